axi4_sub_mem: RTL and testbench



---
 rtl/axi4_sub_mem_if.sv | 73 +++++++
 rtl/axi4_sub_mem.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi4_sub_mem.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_sub_mem_if.sv
// rtl/axi4_sub_mem_if.sv - AXI4 manager/subordinate link carrying AW/W/B/AR/R channels
//
// Purpose: bundles the five AXI4 channels of one manager-to-subordinate link.
// Parameters: ADDR_WIDTH, DATA_WIDTH, ID_WIDTH.
// Modports:
//   Manager     - drives AW/W/AR payload+valid and b_ready/r_ready.
//   Subordinate - drives aw_ready/w_ready/ar_ready and B/R payload+valid.
interface axi4_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  // Write address channel
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_valid;
  logic                    aw_ready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;
  // Write response channel
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  // Read address channel
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_valid;
  logic                    ar_ready;
  // Read data channel
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    r_valid;
  logic                    r_ready;

  modport Manager (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport Subordinate (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi4_sub_mem.sv
// rtl/axi4_sub_mem.sv - AXI4 subordinate scratch RAM with independent write and read FSMs
//
// Purpose: word-addressed RAM behind one AXI4 link. Accepts single, INCR and
// FIXED bursts; WRAP/reserved bursts or a narrow size are handshaken in full
// but answered with SLVERR and never touch memory.
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous active-high reset
//   axi_sub_if - axi4_bus_if.Subordinate (AW/W/B/AR/R)
//   wr_busy_o  - write FSM not idle
//   rd_busy_o  - read FSM not idle
module axi4_sub_mem #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        MEM_DEPTH      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  axi4_bus_if.Subordinate  axi_sub_if,
  output logic             wr_busy_o,
  output logic             rd_busy_o
);

  localparam int AW       = AXI_ADDR_WIDTH;
  localparam int DW       = AXI_DATA_WIDTH;
  localparam int IW       = AXI_ID_WIDTH;
  localparam int BPW      = DW / 8;
  localparam int ADDR_LSB = $clog2(BPW);
  localparam int IDX_W    = $clog2(MEM_DEPTH);

  localparam logic [2:0]    SIZE_FULL = 3'(ADDR_LSB);
  localparam logic [AW-1:0] ADDR_STEP = AW'(BPW);
  localparam logic [1:0]    BURST_INCR = 2'b01;
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, B_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

  logic [DW-1:0] mem_q [MEM_DEPTH];

  // ---------------------------------------------------------------------------
  // Write side state
  // ---------------------------------------------------------------------------
  wr_state_t       wr_state_q, wr_state_d;
  logic [IW-1:0]   wr_id_q, wr_id_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [8:0]      wr_cnt_q, wr_cnt_d;
  logic [1:0]      wr_burst_q, wr_burst_d;
  logic            wr_legal_q, wr_legal_d;
  logic            wr_err_q, wr_err_d;
  logic            wr_mem_en;
  logic            aw_ready, w_ready, b_valid;

  // The extra top bit of the subtraction is the borrow: set when addr < BASE_ADDR.
  logic [AW:0]      wr_ext;
  logic             wr_in_range;
  logic [IDX_W-1:0] wr_idx;

  assign wr_ext      = {1'b0, wr_addr_q} - {1'b0, BASE_ADDR};
  assign wr_in_range = !wr_ext[AW] && (wr_ext[AW-1:ADDR_LSB+IDX_W] == '0);
  assign wr_idx      = wr_ext[ADDR_LSB +: IDX_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_cnt_q   <= '0;
      wr_burst_q <= '0;
      wr_legal_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_burst_q <= wr_burst_d;
      wr_legal_q <= wr_legal_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_addr_d  = wr_addr_q;
    wr_cnt_d   = wr_cnt_q;
    wr_burst_d = wr_burst_q;
    wr_legal_d = wr_legal_q;
    wr_err_d   = wr_err_q;
    wr_mem_en  = 1'b0;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (axi_sub_if.aw_valid) begin
          wr_id_d    = axi_sub_if.aw_id;
          wr_addr_d  = axi_sub_if.aw_addr;
          wr_cnt_d   = {1'b0, axi_sub_if.aw_len} + 9'd1;
          wr_burst_d = axi_sub_if.aw_burst;
          wr_legal_d = !axi_sub_if.aw_burst[1] && (axi_sub_if.aw_size == SIZE_FULL);
          // An illegal burst is pre-flagged so B reports SLVERR regardless of beats.
          wr_err_d   = !wr_legal_d;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi_sub_if.w_valid) begin
          wr_mem_en = wr_legal_q && wr_in_range;
          // The beat counter ends the burst; w_last only feeds the error flag.
          if (!wr_in_range || (axi_sub_if.w_last != (wr_cnt_q == 9'd1))) begin
            wr_err_d = 1'b1;
          end
          wr_cnt_d  = wr_cnt_q - 9'd1;
          wr_addr_d = (wr_burst_q == BURST_INCR) ? wr_addr_q + ADDR_STEP : wr_addr_q;
          if (wr_cnt_q == 9'd1) begin
            wr_state_d = B_RESP;
          end
        end
      end
      B_RESP: begin
        b_valid = 1'b1;
        if (axi_sub_if.b_ready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Byte-enabled write port; memory contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_mem_en) begin
      for (int b = 0; b < BPW; b++) begin
        if (axi_sub_if.w_strb[b]) begin
          mem_q[wr_idx][8*b +: 8] <= axi_sub_if.w_data[8*b +: 8];
        end
      end
    end
  end

  assign axi_sub_if.aw_ready = aw_ready;
  assign axi_sub_if.w_ready  = w_ready;
  assign axi_sub_if.b_valid  = b_valid;
  assign axi_sub_if.b_id     = wr_id_q;
  assign axi_sub_if.b_resp   = wr_err_q ? RESP_SLVERR : RESP_OKAY;
  assign wr_busy_o           = (wr_state_q != W_IDLE);

  // ---------------------------------------------------------------------------
  // Read side state
  // ---------------------------------------------------------------------------
  rd_state_t       rd_state_q, rd_state_d;
  logic [IW-1:0]   rd_id_q, rd_id_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [8:0]      rd_cnt_q, rd_cnt_d;
  logic [1:0]      rd_burst_q, rd_burst_d;
  logic            rd_legal_q, rd_legal_d;
  logic [DW-1:0]   r_data_q, r_data_d;
  logic [1:0]      r_resp_q, r_resp_d;
  logic            r_last_q, r_last_d;
  logic            ar_ready, r_valid;
  logic            rd_hit;

  logic [AW:0]      rd_ext;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;

  assign rd_ext      = {1'b0, rd_addr_q} - {1'b0, BASE_ADDR};
  assign rd_in_range = !rd_ext[AW] && (rd_ext[AW-1:ADDR_LSB+IDX_W] == '0);
  assign rd_idx      = rd_ext[ADDR_LSB +: IDX_W];

  // Byte offset within a word never selects anything: addresses align down.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{wr_ext[ADDR_LSB-1:0], rd_ext[ADDR_LSB-1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_cnt_q   <= '0;
      rd_burst_q <= '0;
      rd_legal_q <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      r_last_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_burst_q <= rd_burst_d;
      rd_legal_q <= rd_legal_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_cnt_d   = rd_cnt_q;
    rd_burst_d = rd_burst_q;
    rd_legal_d = rd_legal_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    ar_ready   = 1'b0;
    r_valid    = 1'b0;
    rd_hit     = rd_legal_q && rd_in_range;
    case (rd_state_q)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (axi_sub_if.ar_valid) begin
          rd_id_d    = axi_sub_if.ar_id;
          rd_addr_d  = axi_sub_if.ar_addr;
          rd_cnt_d   = {1'b0, axi_sub_if.ar_len} + 9'd1;
          rd_burst_d = axi_sub_if.ar_burst;
          rd_legal_d = !axi_sub_if.ar_burst[1] && (axi_sub_if.ar_size == SIZE_FULL);
          rd_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        // Registered read: a write to the same word this cycle lands after
        // the sample, so the beat carries the old data.
        r_data_d   = rd_hit ? mem_q[rd_idx] : '0;
        r_resp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
        r_last_d   = (rd_cnt_q == 9'd1);
        rd_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (axi_sub_if.r_ready) begin
          rd_cnt_d   = rd_cnt_q - 9'd1;
          rd_addr_d  = (rd_burst_q == BURST_INCR) ? rd_addr_q + ADDR_STEP : rd_addr_q;
          rd_state_d = (rd_cnt_q == 9'd1) ? R_IDLE : R_FETCH;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign axi_sub_if.ar_ready = ar_ready;
  assign axi_sub_if.r_valid  = r_valid;
  assign axi_sub_if.r_id     = rd_id_q;
  assign axi_sub_if.r_data   = r_data_q;
  assign axi_sub_if.r_resp   = r_resp_q;
  assign axi_sub_if.r_last   = r_last_q;
  assign rd_busy_o           = (rd_state_q != R_IDLE);

endmodule

// File: tb/tb_axi4_sub_mem.sv
// tb/tb_axi4_sub_mem.sv - directed self-checking bench for axi4_sub_mem
module tb_axi4_sub_mem;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_busy, rd_busy;

  axi4_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) bus ();

  axi4_sub_mem #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
    .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .axi_sub_if(bus),
    .wr_busy_o(wr_busy), .rd_busy_o(rd_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mdl [DEPTH];
  logic [63:0] wbuf [16];

  typedef struct packed { logic [1:0] resp; logic [3:0] id; } bexp_t;
  typedef struct packed { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
  bexp_t exp_b[$];
  rexp_t exp_r[$];
  logic  r_toggle = 1'b0;

  function automatic logic in_range(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off / 8 < DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 8);
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] burst);
    return (burst == INCR) ? a + 32'd8 : a;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.b_valid) begin
        check("b_aw_ready_low", 64'(bus.aw_ready), 64'(0));
        if (exp_b.size() == 0) check("b_unexpected", 64'(exp_b.size()), 64'(1));
        else begin
          check("b_resp", 64'(bus.b_resp), 64'(exp_b[0].resp));
          check("b_id", 64'(bus.b_id), 64'(exp_b[0].id));
          if (bus.b_ready) void'(exp_b.pop_front());
        end
      end
      if (bus.r_valid) begin
        if (exp_r.size() == 0) check("r_unexpected", 64'(exp_r.size()), 64'(1));
        else begin
          check("r_data", bus.r_data, exp_r[0].data);
          check("r_resp", 64'(bus.r_resp), 64'(exp_r[0].resp));
          check("r_last", 64'(bus.r_last), 64'(exp_r[0].last));
          check("r_id", 64'(bus.r_id), 64'(exp_r[0].id));
          if (bus.r_ready) void'(exp_r.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (r_toggle) bus.r_ready = ~bus.r_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id, input logic [7:0] strb,
                             input int bad_last, input int stop_after);
    logic [31:0] a;
    logic legal, err;
    bexp_t be;
    int nb, t;
    nb = int'(len) + 1;
    legal = (burst == FIXED || burst == INCR) && size == 3'd3;
    err = !legal || bad_last != 0;
    a = addr;
    for (int i = 0; i < nb; i++) begin
      if (!in_range(a)) err = 1'b1;
      a = nxt(a, burst);
    end
    be.resp = err ? 2'b10 : 2'b00;
    be.id = id;
    if (stop_after >= nb) exp_b.push_back(be);
    bus.aw_addr = addr; bus.aw_len = len; bus.aw_burst = burst; bus.aw_size = size;
    bus.aw_id = id; bus.aw_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.aw_ready && t < 50);
    check("aw_accept", 64'(bus.aw_ready), 64'(1));
    @(posedge clk); #1 bus.aw_valid = 1'b0;
    a = addr;
    for (int i = 0; i < nb && i < stop_after; i++) begin
      bus.w_data = wbuf[i]; bus.w_strb = strb;
      bus.w_last = (bad_last != 0) ? (i == 0) : (i == nb - 1);
      bus.w_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.w_ready && t < 50);
      check("w_accept", 64'(bus.w_ready), 64'(1));
      if (legal && in_range(a))
        for (int b = 0; b < 8; b++)
          if (strb[b]) mdl[widx(a)][8*b +: 8] = wbuf[i][8*b +: 8];
      a = nxt(a, burst);
      @(posedge clk); #1 bus.w_valid = 1'b0; bus.w_last = 1'b0;
    end
    if (stop_after >= nb) begin
      @(negedge clk);
      check("b_latency", 64'(bus.b_valid), 64'(1));
      t = 0;
      while (exp_b.size() != 0 && t < 60) begin @(posedge clk); #2; t++; end
      check("b_drain", 64'(exp_b.size()), 64'(0));
    end
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id);
    logic [31:0] a;
    logic legal, hit;
    rexp_t re;
    int nb, t;
    nb = int'(len) + 1;
    legal = (burst == FIXED || burst == INCR) && size == 3'd3;
    a = addr;
    for (int i = 0; i < nb; i++) begin
      hit = legal && in_range(a);
      re.data = hit ? mdl[widx(a)] : 64'h0;
      re.resp = hit ? 2'b00 : 2'b10;
      re.last = (i == nb - 1);
      re.id = id;
      exp_r.push_back(re);
      a = nxt(a, burst);
    end
    bus.ar_addr = addr; bus.ar_len = len; bus.ar_burst = burst; bus.ar_size = size;
    bus.ar_id = id; bus.ar_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ar_ready && t < 50);
    check("ar_accept", 64'(bus.ar_ready), 64'(1));
    @(posedge clk); #1 bus.ar_valid = 1'b0;
    @(negedge clk); check("rd_latency_n1", 64'(bus.r_valid), 64'(0));
    @(negedge clk); check("rd_latency_n2", 64'(bus.r_valid), 64'(1));
    t = 0;
    while (exp_r.size() != 0 && t < 200) begin @(posedge clk); #2; t++; end
    check("r_drain", 64'(exp_r.size()), 64'(0));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_aw_ready"}, 64'(bus.aw_ready), 64'(1));
    check({tag, "_ar_ready"}, 64'(bus.ar_ready), 64'(1));
    check({tag, "_w_ready"},  64'(bus.w_ready),  64'(0));
    check({tag, "_b_valid"},  64'(bus.b_valid),  64'(0));
    check({tag, "_r_valid"},  64'(bus.r_valid),  64'(0));
    check({tag, "_r_last"},   64'(bus.r_last),   64'(0));
    check({tag, "_b_resp"},   64'(bus.b_resp),   64'(0));
    check({tag, "_r_resp"},   64'(bus.r_resp),   64'(0));
    check({tag, "_r_data"},   bus.r_data,        64'(0));
    check({tag, "_b_id"},     64'(bus.b_id),     64'(0));
    check({tag, "_r_id"},     64'(bus.r_id),     64'(0));
    check({tag, "_wr_busy"},  64'(wr_busy),      64'(0));
    check({tag, "_rd_busy"},  64'(rd_busy),      64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.b_ready = 1;
    bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
    bus.r_ready = 1;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst_init");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write then read.
    wbuf[0] = 64'hA5A5_0000_1234_5678;
    write_burst(BASE + 32'h10, 8'd0, INCR, 3'd3, 4'h3, 8'hFF, 0, 99);
    read_burst(BASE + 32'h10, 8'd0, INCR, 3'd3, 4'h7);
    check("pin_single", mdl[2], 64'hA5A5_0000_1234_5678);

    // INCR len=3 readback.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
    write_burst(BASE, 8'd3, INCR, 3'd3, 4'h1, 8'hFF, 0, 99);
    read_burst(BASE, 8'd3, INCR, 3'd3, 4'h2);
    check("pin_incr_b3", mdl[3], 64'h4);

    // Strobe: low 4 bytes only.
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(BASE + 32'h80, 8'd0, INCR, 3'd3, 4'h4, 8'hFF, 0, 99);
    wbuf[0] = 64'h1111_2222_3333_4444;
    write_burst(BASE + 32'h80, 8'd0, INCR, 3'd3, 4'h4, 8'h0F, 0, 99);
    read_burst(BASE + 32'h80, 8'd0, INCR, 3'd3, 4'h4);
    check("pin_strobe", mdl[16], 64'hFFFF_FFFF_3333_4444);

    // Range error across the top of memory.
    check("pin_range_last", 64'(in_range(BASE + 32'h1FF8)), 64'(1));
    check("pin_range_past", 64'(in_range(BASE + 32'h2000)), 64'(0));
    wbuf[0] = 64'hDEAD_BEEF_0000_0001; wbuf[1] = 64'hDEAD_BEEF_0000_0002;
    write_burst(BASE + 32'h1FF8, 8'd1, INCR, 3'd3, 4'h5, 8'hFF, 0, 99);
    read_burst(BASE + 32'h1FF8, 8'd1, INCR, 3'd3, 4'h5);

    // Illegal bursts leave memory unchanged.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h4000 + 64'(i);
    write_burst(BASE + 32'h40, 8'd3, INCR, 3'd3, 4'h6, 8'hFF, 0, 99);
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hBAD0 + 64'(i);
    write_burst(BASE + 32'h40, 8'd3, WRAP, 3'd3, 4'h6, 8'hFF, 0, 99);
    read_burst(BASE + 32'h40, 8'd3, WRAP, 3'd3, 4'h6);
    write_burst(BASE + 32'h40, 8'd3, INCR, 3'd2, 4'h8, 8'hFF, 0, 99);
    read_burst(BASE + 32'h40, 8'd3, INCR, 3'd3, 4'h9);
    check("pin_illegal_keep", mdl[8], 64'h4000);

    // Early w_last is an error but the counter still runs the burst.
    wbuf[0] = 64'h33; wbuf[1] = 64'h34;
    write_burst(BASE + 32'h300, 8'd1, INCR, 3'd3, 4'hA, 8'hFF, 1, 99);

    // FIXED burst: last beat wins, reads repeat the same word.
    wbuf[0] = 64'hAAAA; wbuf[1] = 64'hBBBB; wbuf[2] = 64'hCCCC;
    write_burst(BASE + 32'h400, 8'd2, FIXED, 3'd3, 4'hB, 8'hFF, 0, 99);
    read_burst(BASE + 32'h400, 8'd1, FIXED, 3'd3, 4'hB);
    check("pin_fixed", mdl[128], 64'hCCCC);

    // B backpressure.
    bus.b_ready = 1'b0;
    wbuf[0] = 64'h600;
    fork
      write_burst(BASE + 32'h600, 8'd0, INCR, 3'd3, 4'h5, 8'hFF, 0, 99);
      begin : bp_watch
        int t;
        t = 0;
        while (!bus.b_valid && t < 50) begin @(negedge clk); t++; end
        check("bp_b_seen", 64'(bus.b_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_b_hold", 64'(bus.b_valid), 64'(1));
          check("bp_aw_low", 64'(bus.aw_ready), 64'(0));
        end
        @(posedge clk); #1 bus.b_ready = 1'b1;
      end
    join

    // R backpressure with a toggling r_ready.
    r_toggle = 1'b1;
    read_burst(BASE, 8'd3, INCR, 3'd3, 4'hC);
    r_toggle = 1'b0;
    bus.r_ready = 1'b1;

    // Concurrent write and read to disjoint words.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h5000 + 64'(i);
    fork
      write_burst(BASE + 32'h500, 8'd3, INCR, 3'd3, 4'hD, 8'hFF, 0, 99);
      read_burst(BASE, 8'd3, INCR, 3'd3, 4'hE);
    join

    // Reset after 2 of 4 beats.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h7100 + 64'(i);
    write_burst(BASE + 32'h100, 8'd3, INCR, 3'd3, 4'h1, 8'hFF, 0, 2);
    rst = 1'b1;
    #1 check_reset("rst_mid");
    exp_b.delete();
    exp_r.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h7200 + 64'(i);
    write_burst(BASE + 32'h200, 8'd3, INCR, 3'd3, 4'h2, 8'hFF, 0, 99);
    read_burst(BASE + 32'h100, 8'd1, INCR, 3'd3, 4'h3);
    check("pin_abort_keep", mdl[33], 64'h7101);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
